fp_mul_arbiter: RTL and testbench

Shares one `fp_multiplier` instance among `N_REQ` independent requesters.

- Each requester hands over an operand pair on a valid/ready handshake.
- The arbiter grants requesters round-robin and sequences the multiplier's strobe/ack protocol: operand A, then operand B, then product collection.
- The product goes back to the granted requester on a per-requester valid/ready response.
- It sits between the FP execution units and the single multiplier datapath, and allows one multiply in flight at a time.

---
 rtl/fp_mul_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/fp_mul_arbiter.sv | 124 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the round-robin front end of the single
// floating-point multiplier.
package fp_mul_arb_pkg;

  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_P,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first set request at or above
// ptr, searching upward with wrap-around. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0] rot;
  logic         found;
  int           sum;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    rot     = N'({req, req} >> ptr);
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = 0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = int'(ptr) + j;
        if (sum >= N) sum = sum - N;
      end
    end
    if (found) begin
      gnt_idx = IW'(sum);
      gnt     = N'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fp_multiplier among N_REQ requesters: round-robin grant, then
// operand A, operand B and product strobe/ack handshakes, then a per-requester response.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [FP_W*N_REQ-1:0]   req_a,
  input  logic [FP_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [FP_W-1:0]         resp_data,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [FP_W-1:0]         mul_a,
  output logic                    mul_a_stb,
  input  logic                    mul_a_ack,
  output logic [FP_W-1:0]         mul_b,
  output logic                    mul_b_stb,
  input  logic                    mul_b_ack,
  input  logic [FP_W-1:0]         mul_prod,
  input  logic                    mul_prod_stb,
  output logic                    mul_prod_ack,
  output logic [CNT_W-1:0]        ops_done
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state_q,    state_d;
  logic [FP_W-1:0]  op_a_q,     op_a_d;
  logic [FP_W-1:0]  op_b_q,     op_b_d;
  logic [FP_W-1:0]  prod_q,     prod_d;
  logic [IDX_W-1:0] gnt_q,      gnt_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             accept;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // The only combinational input-to-output path: valid -> ready while idle.
  assign req_ready = (state_q == IDLE) ? arb_gnt : '0;
  assign accept    = |(req_valid & req_ready);

  assign mul_a        = (state_q == SEND_A) ? op_a_q : '0;
  assign mul_a_stb    = (state_q == SEND_A);
  assign mul_b        = (state_q == SEND_B) ? op_b_q : '0;
  assign mul_b_stb    = (state_q == SEND_B);
  assign mul_prod_ack = (state_q == WAIT_P);
  assign resp_valid   = (state_q == RESP) ? (N_REQ'(1) << gnt_q) : '0;
  assign resp_data    = prod_q;
  assign ops_done     = ops_done_q;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    prod_d     = prod_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    ops_done_d = ops_done_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = req_a[FP_W*arb_idx +: FP_W];
          op_b_d   = req_b[FP_W*arb_idx +: FP_W];
          gnt_d    = arb_idx;
          rr_ptr_d = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
          state_d  = SEND_A;
        end
      end
      SEND_A: if (mul_a_ack) state_d = SEND_B;
      SEND_B: if (mul_b_ack) state_d = WAIT_P;
      WAIT_P: begin
        if (mul_prod_stb) begin
          prod_d  = mul_prod;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready[gnt_q]) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      prod_q     <= '0;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      prod_q     <= prod_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      ops_done_q <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: directed requests push expected
// (requester, product) pairs; a monitor pops and compares on every response handshake.
module tb_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     resp_data, mul_a, mul_b, mul_prod;
  logic            mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack, mul_prod_stb, mul_prod_ack;
  logic [CW-1:0]   ops_done;
  logic [31:0]     a_v [N];
  logic [31:0]     b_v [N];

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   exp_ops = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_v[i];
      req_b[32*i +: 32] = b_v[i];
    end
  end

  fp_mul_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .mul_a        (mul_a),
    .mul_a_stb    (mul_a_stb),
    .mul_a_ack    (mul_a_ack),
    .mul_b        (mul_b),
    .mul_b_stb    (mul_b_stb),
    .mul_b_ack    (mul_b_ack),
    .mul_prod     (mul_prod),
    .mul_prod_stb (mul_prod_stb),
    .mul_prod_ack (mul_prod_ack),
    .ops_done     (ops_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Normal-operand multiply with truncation; exact for the vectors used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int          e;
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) return {a[31] ^ b[31], 8'(e + 1), m[46:24]};
    return {a[31] ^ b[31], 8'(e), m[45:23]};
  endfunction

  // Multiplier stand-in: acks each operand two cycles into its strobe, then
  // presents the product three cycles after operand B; cleared by reset.
  initial begin : mul_model
    int          ph;
    int          cnt;
    logic [31:0] ma, mb;
    ph = 0; cnt = 0; ma = '0; mb = '0;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_prod_stb = 1'b0; mul_prod = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        ph = 0; cnt = 0;
        mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_prod_stb = 1'b0;
      end else begin
        case (ph)
          0: if (mul_a_ack) begin
               mul_a_ack = 1'b0; cnt = 0; ph = 1;
             end else if (mul_a_stb) begin
               cnt++;
               if (cnt >= 2) begin ma = mul_a; mul_a_ack = 1'b1; end
             end
          1: if (mul_b_ack) begin
               mul_b_ack = 1'b0; cnt = 0; ph = 2;
             end else if (mul_b_stb) begin
               cnt++;
               if (cnt >= 2) begin mb = mul_b; mul_b_ack = 1'b1; end
             end
          2: begin
               cnt++;
               if (cnt >= 3) begin mul_prod = fmul(ma, mb); mul_prod_stb = 1'b1; ph = 3; end
             end
          default: if (!mul_prod_ack) begin mul_prod_stb = 1'b0; ph = 0; end
        endcase
      end
    end
  end

  initial begin : monitor
    bit   ops_pend, a_prev, b_prev, p_prev;
    exp_t e;
    ops_pend = 0; a_prev = 0; b_prev = 0; p_prev = 0;
    forever begin
      @(negedge clk); #4;
      if (reset) begin
        sb.delete();
        exp_ops = 0; ops_pend = 0; a_prev = 0; b_prev = 0; p_prev = 0;
        continue;
      end
      if (ops_pend) begin
        check("ops_done", 32'(ops_done), 32'(exp_ops % (1 << CW)));
        ops_pend = 0;
      end
      if (a_prev) check("a_stb_drop", 32'(mul_a_stb), 32'd0);
      if (b_prev) check("b_stb_drop", 32'(mul_b_stb), 32'd0);
      if (p_prev) check("prod_ack_drop", 32'(mul_prod_ack), 32'd0);
      a_prev = mul_a_stb & mul_a_ack;
      b_prev = mul_b_stb & mul_b_ack;
      p_prev = mul_prod_stb & mul_prod_ack;
      if (|(resp_valid & resp_ready)) begin
        if (sb.size() == 0) begin
          fail("unexpected_resp");
        end else begin
          e = sb.pop_front();
          check("resp_valid", 32'(resp_valid), 32'(1) << e.idx);
          check("resp_data", resp_data, e.data);
          exp_ops++;
          ops_pend = 1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #3;
  endtask

  task automatic wait_grant(input int g, input logic [31:0] prod);
    int n;
    n = 0;
    #1;
    while (!(|(req_ready & req_valid)) && n < 200) begin
      tick(); #1;
      n++;
    end
    if (n >= 200) begin
      fail("grant_timeout");
    end else begin
      check("grant", 32'(req_ready), 32'(1) << g);
      sb.push_back('{g, prod});
    end
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail("drain_timeout");
    tick(); tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),    32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid),   32'd0);
    check({tag, "_resp_data"},  resp_data,         32'd0);
    check({tag, "_mul_a"},      mul_a,             32'd0);
    check({tag, "_mul_a_stb"},  32'(mul_a_stb),    32'd0);
    check({tag, "_mul_b"},      mul_b,             32'd0);
    check({tag, "_mul_b_stb"},  32'(mul_b_stb),    32'd0);
    check({tag, "_prod_ack"},   32'(mul_prod_ack), 32'd0);
    check({tag, "_ops_done"},   32'(ops_done),     32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          n;
    logic [31:0] bk;
    reset = 1'b1;
    req_valid = '0;
    resp_ready = '1;
    for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
    tick(); tick();
    check_reset_vals("init");
    reset = 1'b0;
    tick();

    // Single request: 2.0 * 3.0 = 6.0, strobe A the cycle after acceptance.
    a_v[0] = 32'h4000_0000; b_v[0] = 32'h4040_0000;
    req_valid = 4'b0001;
    wait_grant(0, 32'h40C0_0000);
    req_valid = '0;
    check("a_stb_after_accept", 32'(mul_a_stb), 32'd1);
    check("mul_a_value", mul_a, 32'h4000_0000);
    drain();
    check("ops_after_first", 32'(ops_done), 32'd1);

    // All four held valid from rr_ptr=0: rotation 0,1,2,3,0.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int i = 0; i < N; i++) a_v[i] = 32'h3F80_0000;
    b_v[0] = 32'h4000_0000; b_v[1] = 32'h4040_0000;
    b_v[2] = 32'h3F00_0000; b_v[3] = 32'hBFC0_0000;
    req_valid = 4'b1111;
    wait_grant(0, 32'h4000_0000);
    wait_grant(1, 32'h4040_0000);
    wait_grant(2, 32'h3F00_0000);
    wait_grant(3, 32'hBFC0_0000);
    wait_grant(0, 32'h4000_0000);
    req_valid = '0;
    drain();

    // Move rr_ptr to 2, then requesters 0 and 1 valid: grant 0, then 1.
    req_valid = 4'b0010;
    wait_grant(1, 32'h4040_0000);
    req_valid = '0;
    drain();
    req_valid = 4'b0011;
    wait_grant(0, 32'h4000_0000);
    wait_grant(1, 32'h4040_0000);
    req_valid = '0;
    drain();

    // Backpressure on requester 1 while requester 0 waits.
    a_v[1] = 32'h4000_0000; b_v[1] = 32'h4000_0000;
    b_v[0] = 32'h4120_0000;
    resp_ready = 4'b1101;
    req_valid = 4'b0010;
    wait_grant(1, 32'h4080_0000);
    req_valid = 4'b0001;
    n = 0;
    while (!resp_valid[1] && n < 100) begin tick(); n++; end
    if (n >= 100) fail("resp1_timeout");
    for (int k = 0; k < 10; k++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'h2);
      check("bp_resp_data", resp_data, 32'h4080_0000);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = '1;
    wait_grant(0, 32'h4120_0000);
    req_valid = '0;
    drain();

    // Reset while operand B is being offered; in-flight work is dropped.
    a_v[2] = 32'h4040_0000; b_v[2] = 32'h4040_0000;
    req_valid = 4'b0100;
    wait_grant(2, 32'h4110_0000);
    req_valid = '0;
    n = 0;
    while (!mul_b_stb && n < 100) begin tick(); n++; end
    if (n >= 100) fail("send_b_timeout");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midop");
    a_v[0] = 32'h3F80_0000; b_v[0] = 32'hC000_0000;
    req_valid = 4'b0001;
    wait_grant(0, 32'hC000_0000);
    req_valid = '0;
    drain();

    // Sixteen more operations take the 4-bit counter from 1 through 0 back to 1.
    for (int k = 0; k < 16; k++) begin
      bk = {1'b0, 8'd128, 7'(k), 16'd0};
      a_v[k % N] = 32'h3F80_0000;
      b_v[k % N] = bk;
      req_valid = 4'(1 << (k % N));
      wait_grant(k % N, bk);
      req_valid = '0;
      drain();
      if (k == 14) check("ops_rollover_zero", 32'(ops_done), 32'd0);
    end
    check("ops_wrap", 32'(ops_done), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
